// File: rtl/matrix_mult_mul_arbiter_if.sv
// Bundle between the multiplier arbiter (slave), its requesters, the shared
// registered multiplier and the product consumer (master side).
interface matrix_mult_mul_arbiter_if #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned A_WIDTH  = 14,
    parameter int unsigned B_WIDTH  = 14,
    parameter int unsigned P_WIDTH  = 28,
    parameter int unsigned ID_WIDTH = 1
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*A_WIDTH-1:0] req_a;
    logic [NUM_REQ*B_WIDTH-1:0] req_b;
    logic                       mul_ce;
    logic [A_WIDTH-1:0]         mul_din0;
    logic [B_WIDTH-1:0]         mul_din1;
    logic [P_WIDTH-1:0]         mul_dout;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [ID_WIDTH-1:0]        resp_id;
    logic [P_WIDTH-1:0]         resp_data;

    modport master (
        output req_valid, req_a, req_b, mul_dout, resp_ready,
        input  req_ready, mul_ce, mul_din0, mul_din1, resp_valid, resp_id, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_dout, resp_ready,
        output req_ready, mul_ce, mul_din0, mul_din1, resp_valid, resp_id, resp_data
    );
endinterface

// File: rtl/matrix_mult_mul_arbiter.sv
// Round-robin sharing of one registered multiplier among NUM_REQ requesters;
// s1_* shadows the multiplier output register so each product carries its requester id.
module matrix_mult_mul_arbiter #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned A_WIDTH  = 14,
    parameter int unsigned B_WIDTH  = 14,
    parameter int unsigned P_WIDTH  = 28,
    parameter int unsigned ID_WIDTH = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    matrix_mult_mul_arbiter_if.slave  bus
);
    logic                s1_vld_q, s1_vld_d;
    logic [ID_WIDTH-1:0] s1_id_q, s1_id_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                advance;
    logic                granted;
    int unsigned         gidx;
    int unsigned         idx;

    // Scan from rr_ptr with wrap; the first valid requester wins.
    always_comb begin
        advance = !s1_vld_q || bus.resp_ready;
        granted = 1'b0;
        gidx    = 0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!granted && bus.req_valid[idx]) begin
                granted = 1'b1;
                gidx    = idx;
            end
        end
        granted = granted && advance && !reset;
    end

    always_comb begin
        bus.req_ready = '0;
        bus.mul_din0  = '0;
        bus.mul_din1  = '0;
        if (granted) begin
            bus.req_ready[gidx] = 1'b1;
            bus.mul_din0        = bus.req_a[gidx*A_WIDTH +: A_WIDTH];
            bus.mul_din1        = bus.req_b[gidx*B_WIDTH +: B_WIDTH];
        end
        bus.mul_ce     = advance || reset;
        bus.resp_valid = s1_vld_q && !reset;
        bus.resp_id    = s1_id_q;
        bus.resp_data  = bus.mul_dout;
    end

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_id_d  = s1_id_q;
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            s1_vld_d = granted;
            if (granted) begin
                s1_id_d  = ID_WIDTH'(gidx);
                rr_ptr_d = (gidx == NUM_REQ - 1) ? '0 : ID_WIDTH'(gidx + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
            s1_id_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_id_q  <= s1_id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end
endmodule
